// File: rtl/adder_result_checker.sv
// adder_result_checker
//   Self-checking stage placed directly downstream of a registered WIDTH-bit
//   adder. It issues a programmed number of operand vectors. For each accepted
//   vector it computes the golden a+b+cin at WIDTH+1 bits and delays it by
//   LATENCY cycles. It then compares the delayed value with the adder's
//   {cout,sum}, and reports the vector count, the error count and the first
//   failing index.
//
//   Optional feature macro: ADDER_CHK_LOG_EN
//     defined   : first_exp/first_got capture the expected and observed value
//                 of the first mismatch.
//     undefined : first_exp/first_got are tied to 0 and no capture registers
//                 exist.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start, n_vectors    begin a run (accepted in IDLE/DONE), vector count
//   in_valid, in_ready  vector handshake; a/b/cin are also driven to the adder
//   a, b, cin           operands and carry-in
//   sum, cout           adder outputs, valid LATENCY cycles after the operands
//   busy, done, pass    status: RUN/DRAIN, DONE, DONE with zero errors
//   vec_cnt, err_cnt    vectors compared, mismatches (saturating)
//   first_err_idx       vec_cnt at the first mismatch, all-ones if none
//   first_exp/first_got {cout,sum} expected/observed at the first mismatch
module adder_result_checker #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH:0]   first_exp,
  output logic [WIDTH:0]   first_got
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;

  // Golden-result delay line; stage LATENCY-1 lines up with the adder output.
  logic [LATENCY-1:0] vld_p_q, vld_p_d;
  logic [WIDTH:0]     exp_p_q [LATENCY];
  logic [WIDTH:0]     exp_p_d [LATENCY];

  logic           start_ok;
  logic           accept;
  logic           cmp_vld;
  logic           mism;
  logic           capture;
  logic [WIDTH:0] got;

  function automatic logic [WIDTH:0] golden_sum(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic             c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  assign in_ready = (state_q == S_RUN) && (issued_q < n_q);
  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);
  assign pass     = done && (err_cnt_q == '0);

  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_idx_q;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign accept   = in_valid && in_ready;
  assign got      = {cout, sum};
  assign cmp_vld  = vld_p_q[LATENCY-1];
  assign mism     = cmp_vld && (got != exp_p_q[LATENCY-1]);
  assign capture  = mism && (err_cnt_q == '0);

  // Stage p0: push a tagged slot (or a bubble) every cycle.
  always_comb begin
    vld_p_d    = '0;
    vld_p_d[0] = accept;
    exp_p_d[0] = golden_sum(a, b, cin);
    for (int i = 1; i < LATENCY; i++) begin
      vld_p_d[i] = vld_p_q[i-1];
      exp_p_d[i] = exp_p_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issued_d    = issued_q;
    vec_cnt_d   = vec_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_idx_d = first_idx_q;

    if (accept) issued_d = issued_q + 1'b1;

    // Compare stage: only tagged slots reach the counters.
    if (cmp_vld) vec_cnt_d = vec_cnt_q + 1'b1;
    if (mism)    err_cnt_d = sat_inc(err_cnt_q);
    if (capture) first_idx_d = vec_cnt_q;

    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN:   if (issued_q == n_q) state_d = S_DRAIN;
      S_DRAIN: if (vld_p_q == '0) state_d = S_DONE;
      S_DONE:  if (start_ok) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // No slots are in flight in IDLE/DONE, so a new run can clear everything.
    if (start_ok) begin
      n_d         = n_vectors;
      issued_d    = '0;
      vec_cnt_d   = '0;
      err_cnt_d   = '0;
      first_idx_d = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      issued_q    <= '0;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      first_idx_q <= '1;
      vld_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      vec_cnt_q   <= vec_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_idx_q <= first_idx_d;
      vld_p_q     <= vld_p_d;
    end
  end

  // Golden data carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++) exp_p_q[i] <= exp_p_d[i];
  end

`ifdef ADDER_CHK_LOG_EN
  logic [WIDTH:0] first_exp_q, first_exp_d;
  logic [WIDTH:0] first_got_q, first_got_d;

  always_comb begin
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    if (capture) begin
      first_exp_d = exp_p_q[LATENCY-1];
      first_got_d = got;
    end
    if (start_ok) begin
      first_exp_d = '0;
      first_got_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_exp_q <= '0;
      first_got_q <= '0;
    end else begin
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
    end
  end

  assign first_exp = first_exp_q;
  assign first_got = first_got_q;
`else
  assign first_exp = '0;
  assign first_got = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// tb_adder_result_checker
//   Directed bench for adder_result_checker. It contains a two-stage
//   registered 8-bit adder model whose Sum bit 0 can be forced to 0 (stuck).
//   The model's outputs feed the checker's sum/cout inputs.
module tb_adder_result_checker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_vectors;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy, done, pass;
  logic [CNT_W-1:0] vec_cnt, err_cnt, first_err_idx;
  logic [WIDTH:0]   first_exp, first_got;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(WIDTH), .LATENCY(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_vectors(n_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .first_err_idx(first_err_idx),
    .first_exp(first_exp), .first_got(first_got)
  );

  // Adder under test: input register, then output register.
  logic             stuck;
  logic [WIDTH-1:0] a_r, b_r;
  logic             c_r;
  logic [WIDTH:0]   res_r;
  always_ff @(posedge clk) begin
    a_r   <= a;
    b_r   <= b;
    c_r   <= cin;
    res_r <= ({1'b0, a_r} + {1'b0, b_r} + {8'd0, c_r}) & {8'hFF, ~stuck};
  end
  assign sum  = res_r[WIDTH-1:0];
  assign cout = res_r[WIDTH];

  int checks   = 0;
  int failures = 0;
  int acc_cnt;

  logic [7:0] tv_a [8];
  logic [7:0] tv_b [8];
  logic       tv_c [8];
  logic       tv_v [8];

  task automatic check_eq(input string tag, input logic [31:0] got_v,
                          input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic vv);
    tv_a[i] = va; tv_b[i] = vb; tv_c[i] = vc; tv_v[i] = vv;
  endtask

  // Start a run of n vectors, then drive len table entries on consecutive
  // cycles. If pulse_at >= 0, start is pulsed (with n_vectors=1) while entry
  // pulse_at is driven. Accepts are counted, then the bench waits for done.
  task automatic run_vec(input int n, input int len, input int pulse_at);
    @(negedge clk);
    start = 1'b1; n_vectors = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < len; i++) begin
      a = tv_a[i]; b = tv_b[i]; cin = tv_c[i]; in_valid = tv_v[i];
      if (i == pulse_at) begin
        start = 1'b1; n_vectors = 16'd1;
      end
      if (in_valid && in_ready) acc_cnt++;
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    check_eq("done_reached", 32'(done), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_vectors = '0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0; stuck = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_pass", 32'(pass), 32'd0);
    check_eq("rst_vec_cnt", 32'(vec_cnt), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_first_idx", 32'(first_err_idx), 32'hFFFF);
    check_eq("rst_first_exp", 32'(first_exp), 32'd0);
    check_eq("rst_first_got", 32'(first_got), 32'd0);

    // Golden adder, four back-to-back vectors, carry-out boundaries
    set_vec(0, 8'd0,   8'd0,   1'b0, 1'b1);
    set_vec(1, 8'd255, 8'd1,   1'b0, 1'b1);
    set_vec(2, 8'd255, 8'd255, 1'b1, 1'b1);
    set_vec(3, 8'd128, 8'd128, 1'b0, 1'b1);
    run_vec(4, 4, -1);
    check_eq("gold_accepts", 32'(acc_cnt), 32'd4);
    check_eq("gold_vec_cnt", 32'(vec_cnt), 32'd4);
    check_eq("gold_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("gold_pass", 32'(pass), 32'd1);
    check_eq("gold_first_idx", 32'(first_err_idx), 32'hFFFF);
    check_eq("gold_busy", 32'(busy), 32'd0);

    // Sum bit0 stuck-at-0: (1,0,0) and (3,0,0) fail, (2,0,0) passes
    stuck = 1'b1;
    set_vec(0, 8'd1, 8'd0, 1'b0, 1'b1);
    set_vec(1, 8'd2, 8'd0, 1'b0, 1'b1);
    set_vec(2, 8'd3, 8'd0, 1'b0, 1'b1);
    run_vec(3, 3, -1);
    check_eq("stuck_vec_cnt", 32'(vec_cnt), 32'd3);
    check_eq("stuck_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("stuck_first_idx", 32'(first_err_idx), 32'd0);
    check_eq("stuck_pass", 32'(pass), 32'd0);
`ifdef ADDER_CHK_LOG_EN
    check_eq("stuck_first_exp", 32'(first_exp), 32'h001);
    check_eq("stuck_first_got", 32'(first_got), 32'h000);
`else
    check_eq("stuck_first_exp", 32'(first_exp), 32'h000);
    check_eq("stuck_first_got", 32'(first_got), 32'h000);
`endif

    // in_valid 1,0,0,1,1: the bubbles carry odd sums the stuck adder would
    // miss, so any bubble compared would raise err_cnt.
    set_vec(0, 8'd2, 8'd2, 1'b0, 1'b1);
    set_vec(1, 8'd1, 8'd0, 1'b0, 1'b0);
    set_vec(2, 8'd3, 8'd0, 1'b0, 1'b0);
    set_vec(3, 8'd4, 8'd0, 1'b0, 1'b1);
    set_vec(4, 8'd6, 8'd2, 1'b0, 1'b1);
    run_vec(3, 5, -1);
    check_eq("bubble_accepts", 32'(acc_cnt), 32'd3);
    check_eq("bubble_vec_cnt", 32'(vec_cnt), 32'd3);
    check_eq("bubble_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("bubble_pass", 32'(pass), 32'd1);
    stuck = 1'b0;

    // n_vectors = 0: nothing accepted even with in_valid held high
    set_vec(0, 8'd9, 8'd9, 1'b0, 1'b1);
    set_vec(1, 8'd9, 8'd9, 1'b0, 1'b1);
    set_vec(2, 8'd9, 8'd9, 1'b0, 1'b1);
    run_vec(0, 3, -1);
    check_eq("zero_accepts", 32'(acc_cnt), 32'd0);
    check_eq("zero_vec_cnt", 32'(vec_cnt), 32'd0);
    check_eq("zero_pass", 32'(pass), 32'd1);

    // Reset after 2 of 5 vectors
    @(negedge clk);
    start = 1'b1; n_vectors = 16'd5;
    @(negedge clk);
    start = 1'b0;
    a = 8'd10; b = 8'd20; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 8'd30; b = 8'd40;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_in_ready", 32'(in_ready), 32'd0);
    check_eq("abort_vec_cnt", 32'(vec_cnt), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("abort_no_late_cmp", 32'(vec_cnt), 32'd0);
    set_vec(0, 8'd100, 8'd27, 1'b1, 1'b1);
    set_vec(1, 8'd200, 8'd99, 1'b0, 1'b1);
    run_vec(2, 2, -1);
    check_eq("rerun_vec_cnt", 32'(vec_cnt), 32'd2);
    check_eq("rerun_pass", 32'(pass), 32'd1);

    // Stuck adder, three odd sums -> err_cnt 3; start pulsed in RUN is ignored
    stuck = 1'b1;
    set_vec(0, 8'd1, 8'd0, 1'b0, 1'b1);
    set_vec(1, 8'd3, 8'd0, 1'b0, 1'b1);
    set_vec(2, 8'd5, 8'd0, 1'b0, 1'b1);
    run_vec(3, 3, 1);
    check_eq("ign_accepts", 32'(acc_cnt), 32'd3);
    check_eq("ign_vec_cnt", 32'(vec_cnt), 32'd3);
    check_eq("ign_err_cnt", 32'(err_cnt), 32'd3);
    check_eq("ign_first_idx", 32'(first_err_idx), 32'd0);
    stuck = 1'b0;

    // Start from DONE with n_vectors=1 clears the old errors
    set_vec(0, 8'd10, 8'd20, 1'b1, 1'b1);
    run_vec(1, 1, -1);
    check_eq("redo_vec_cnt", 32'(vec_cnt), 32'd1);
    check_eq("redo_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("redo_first_idx", 32'(first_err_idx), 32'hFFFF);
    check_eq("redo_pass", 32'(pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
